// File: rtl/instr_encode_pkg.sv
// Shared RV32I ISA definitions: instruction formats, word type, opcodes and
// the FIFO entry layout used by the encoder. The decoder imports the same
// package so both blocks agree on one set of opcode values.
package instr_encode_pkg;

  typedef enum logic [3:0] {
    FMT_R     = 4'd0,
    FMT_I     = 4'd1,
    FMT_MI    = 4'd2,
    FMT_S     = 4'd3,
    FMT_B     = 4'd4,
    FMT_LUI   = 4'd5,
    FMT_AUIPC = 4'd6,
    FMT_JAL   = 4'd7,
    FMT_JALR  = 4'd8
  } fmt_t;

  typedef logic [31:0] instruction_t;

  localparam logic [6:0] OPC_R     = 7'h33;
  localparam logic [6:0] OPC_I     = 7'h13;
  localparam logic [6:0] OPC_MI    = 7'h03;
  localparam logic [6:0] OPC_S     = 7'h23;
  localparam logic [6:0] OPC_B     = 7'h63;
  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_JAL   = 7'h6F;
  localparam logic [6:0] OPC_JALR  = 7'h67;

  // One buffered result: legality flag plus the encoded word.
  typedef struct packed {
    logic         err;
    instruction_t instr;
  } entry_t;

  // True when imm[31:msb] are all equal, i.e. the value is a sign extension
  // of its low msb+1 bits and fits the target immediate field.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
    logic signed [31:0] s;
    s = $signed(imm) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_encode_if.sv
// Record/word handshake bundle for the encoder.
// master: producer of records and consumer of words (drives in_*, out_ready).
// slave : the encoder (drives in_ready, out_valid, out_instr, out_err, count).
interface instr_encode_if;
  import instr_encode_pkg::*;

  logic         in_valid;
  logic         in_ready;
  fmt_t         in_fmt;
  logic [4:0]   in_rd;
  logic [4:0]   in_rs1;
  logic [4:0]   in_rs2;
  logic [2:0]   in_funct3;
  logic [6:0]   in_funct7;
  logic [31:0]  in_imm;
  logic         out_valid;
  logic         out_ready;
  instruction_t out_instr;
  logic         out_err;
  logic [15:0]  count;

  modport master (
    output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, count
  );

  modport slave (
    input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, count
  );

endinterface

// File: rtl/instr_pack.sv
// Packs an instruction record into an RV32I word and flags illegal records.
// Purely combinational, zero latency, no backpressure.
// Ports: fmt_i/rd_i/rs1_i/rs2_i/funct3_i/funct7_i/imm_i in; instr_o, err_o out.
module instr_pack
  import instr_encode_pkg::*;
(
  input  fmt_t         fmt_i,
  input  logic [4:0]   rd_i,
  input  logic [4:0]   rs1_i,
  input  logic [4:0]   rs2_i,
  input  logic [2:0]   funct3_i,
  input  logic [6:0]   funct7_i,
  input  logic [31:0]  imm_i,
  output instruction_t instr_o,
  output logic         err_o
);

  instruction_t word;
  logic         bad;

  always_comb begin
    word = '0;
    bad  = 1'b0;
    case (fmt_i)
      FMT_R:     word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OPC_R};
      FMT_I: begin
        word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_I};
        bad  = !imm_fits(imm_i, 11);
      end
      FMT_MI: begin
        word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_MI};
        bad  = !imm_fits(imm_i, 11);
      end
      FMT_JALR: begin
        // JALR has a single encoding, its funct3 field is always 000.
        word = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
        bad  = !imm_fits(imm_i, 11);
      end
      FMT_S: begin
        word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_S};
        bad  = !imm_fits(imm_i, 11);
      end
      FMT_B: begin
        word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], OPC_B};
        bad  = !imm_fits(imm_i, 12) || imm_i[0];
      end
      FMT_LUI: begin
        word = {imm_i[31:12], rd_i, OPC_LUI};
        bad  = (imm_i[11:0] != 12'h000);
      end
      FMT_AUIPC: begin
        word = {imm_i[31:12], rd_i, OPC_AUIPC};
        bad  = (imm_i[11:0] != 12'h000);
      end
      FMT_JAL: begin
        word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
        bad  = !imm_fits(imm_i, 20) || imm_i[0];
      end
      default:   bad = 1'b1;
    endcase
  end

  // Illegal records always produce an all-zero word.
  assign err_o   = bad;
  assign instr_o = bad ? '0 : word;

endmodule

// File: rtl/instr_encode.sv
// RV32I instruction encoder: record in, packed word out through a 2-entry FIFO.
// Latency 1 cycle from accept to out_valid when the FIFO is empty.
// in_ready = FIFO not full (independent of in_valid); words hold while out_ready=0.
// Ports: clk, rst (async, active-high), bus (instr_encode_if.slave).
module instr_encode
  import instr_encode_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  instr_encode_if.slave bus
);

  instruction_t pack_instr;
  logic         pack_err;

  instr_pack u_pack (
    .fmt_i    (bus.in_fmt),
    .rd_i     (bus.in_rd),
    .rs1_i    (bus.in_rs1),
    .rs2_i    (bus.in_rs2),
    .funct3_i (bus.in_funct3),
    .funct7_i (bus.in_funct7),
    .imm_i    (bus.in_imm),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  entry_t      mem_q [2];
  entry_t      mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  occ_q, occ_d;
  logic [15:0] count_q, count_d;

  logic   push, pop;
  entry_t head;

  assign bus.in_ready  = (occ_q != 2'd2);
  assign bus.out_valid = (occ_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign head          = mem_q[rd_ptr_q];
  assign bus.out_instr = bus.out_valid ? head.instr : '0;
  assign bus.out_err   = bus.out_valid & head.err;
  assign bus.count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{err: pack_err, instr: pack_instr};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      count_d  = count_q + 16'd1;   // wraps naturally at 16 bits
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      count_q  <= 16'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_encode.sv
module tb_instr_encode;
  import instr_encode_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_encode_if bus();

  instr_encode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [3:0]  f;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } rec_t;

  int bnd [14] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                   1048574, 1048575, 1048576, -1048576, -1048578};

  // Reference: field placement by shifting/masking and legality by numeric range.
  function automatic logic [32:0] ref_encode(input rec_t r);
    int          s;
    logic [31:0] w;
    logic [31:0] im;
    bit          bad;
    s   = $signed(r.imm);
    im  = r.imm;
    w   = 32'h0;
    bad = 1'b0;
    case (r.f)
      4'd0: w = (32'(r.f7) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) |
                (32'(r.f3) << 12) | (32'(r.rd) << 7) | 32'h33;
      4'd1, 4'd2, 4'd8: begin
        bad = (s < -2048) || (s > 2047);
        w = ((im & 32'hFFF) << 20) | (32'(r.rs1) << 15) | (32'(r.rd) << 7);
        if (r.f == 4'd1) w = w | (32'(r.f3) << 12) | 32'h13;
        else if (r.f == 4'd2) w = w | (32'(r.f3) << 12) | 32'h03;
        else w = w | 32'h67;
      end
      4'd3: begin
        bad = (s < -2048) || (s > 2047);
        w = (((im >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) |
            (32'(r.f3) << 12) | ((im & 32'h1F) << 7) | 32'h23;
      end
      4'd4: begin
        bad = (s < -4096) || (s > 4095) || ((s & 1) != 0);
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(r.rs2) << 20) |
            (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (((im >> 1) & 32'hF) << 8) |
            (((im >> 11) & 1) << 7) | 32'h63;
      end
      4'd5, 4'd6: begin
        bad = (im % 4096) != 0;
        w = (im & 32'hFFFFF000) | (32'(r.rd) << 7) | ((r.f == 4'd5) ? 32'h37 : 32'h17);
      end
      4'd7: begin
        bad = (s < -1048576) || (s > 1048575) || ((s & 1) != 0);
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
            (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) |
            (32'(r.rd) << 7) | 32'h6F;
      end
      default: bad = 1'b1;
    endcase
    if (bad) w = 32'h0;
    return {bad, w};
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    int   k;
    k     = int'($urandom_range(0, 10));
    r.f   = (k > 8) ? 4'($urandom_range(9, 15)) : 4'(k);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom);
    r.f7  = 7'($urandom);
    case ($urandom_range(0, 5))
      0:       r.imm = 32'(int'($urandom_range(0, 32)) - 16);
      1:       r.imm = $urandom;
      2:       r.imm = 32'(bnd[$urandom_range(0, 13)]);
      3:       r.imm = $urandom & 32'hFFFFF000;
      4:       r.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      default: r.imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
    endcase
    return r;
  endfunction

  function automatic rec_t mk(input logic [3:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
    rec_t r;
    r.f = f; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  task automatic drive_rec(input rec_t r);
    bus.in_fmt    = fmt_t'(r.f);
    bus.in_rd     = r.rd;
    bus.in_rs1    = r.rs1;
    bus.in_rs2    = r.rs2;
    bus.in_funct3 = r.f3;
    bus.in_funct7 = r.f7;
    bus.in_imm    = r.imm;
  endtask

  // Called and returning at 1 time unit after a rising edge.
  task automatic apply_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Offers one record and returns 1 time unit after the accepting edge.
  task automatic send_one(input rec_t r, output bit ok);
    ok = 1'b0;
    drive_rec(r);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    drive_rec(mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
    #12;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passes++;
    checks++; if (bus.count !== 16'd0) $display("FAIL reset_count got %0d want 0", bus.count); else passes++;
    checks++; if (bus.out_instr !== 32'h0 || bus.out_err !== 1'b0)
      $display("FAIL reset_word got %h/%b want 0/0", bus.out_instr, bus.out_err); else passes++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    rec_t            vec [5];
    logic [31:0]     wexp [5];
    logic            eexp [5];
    bit              ok;
    apply_reset();
    bus.out_ready = 1'b1;
    vec[0] = mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);          wexp[0] = 32'h00500093; eexp[0] = 1'b0;
    vec[1] = mk(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);          wexp[1] = 32'h002081B3; eexp[1] = 1'b0;
    vec[2] = mk(4'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);   wexp[2] = 32'h123452B7; eexp[2] = 1'b0;
    vec[3] = mk(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);          wexp[3] = 32'h008000EF; eexp[3] = 1'b0;
    vec[4] = mk(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);          wexp[4] = 32'h00000000; eexp[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_one(vec[i], ok);
      checks++; if (!ok) $display("FAIL dir%0d_accept timed out", i); else passes++;
      checks++; if (bus.out_valid !== 1'b1) $display("FAIL dir%0d_latency out_valid got %b want 1", i, bus.out_valid); else passes++;
      checks++; if (bus.out_instr !== wexp[i] || bus.out_err !== eexp[i])
        $display("FAIL dir%0d_word got %h/%b want %h/%b", i, bus.out_instr, bus.out_err, wexp[i], eexp[i]); else passes++;
      @(posedge clk); #1;
      checks++; if (bus.count !== 16'(i + 1)) $display("FAIL dir%0d_count got %0d want %0d", i, bus.count, i + 1); else passes++;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [32:0] sb [$];
    logic [15:0] expc;
    apply_reset();
    expc = 16'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rec_t r;
      bit   push, pop;
      r = rand_rec();
      drive_rec(r);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      push = bus.in_valid && (sb.size() < 2);
      pop  = bus.out_ready && (sb.size() > 0);
      checks++; if (bus.in_ready !== (sb.size() < 2))
        $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, bus.in_ready, sb.size() < 2); else passes++;
      checks++; if (bus.out_valid !== (sb.size() > 0))
        $display("FAIL rnd_out_valid cyc %0d got %b want %b", cyc, bus.out_valid, sb.size() > 0); else passes++;
      checks++; if (bus.count !== expc) $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, bus.count, expc); else passes++;
      if (pop) begin
        checks++; if ({bus.out_err, bus.out_instr} !== sb[0])
          $display("FAIL rnd_word cyc %0d got %b/%h want %b/%h", cyc, bus.out_err, bus.out_instr, sb[0][32], sb[0][31:0]);
        else passes++;
        void'(sb.pop_front());
        expc = expc + 16'd1;
      end
      if (push) sb.push_back(ref_encode(r));
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    rec_t        recs [3];
    logic [32:0] ex [3];
    int          idx;
    apply_reset();
    recs[0] = mk(4'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd100);
    recs[1] = mk(4'd3, 5'd0, 5'd4, 5'd5, 3'd2, 7'd0, 32'hFFFFFFF0);
    recs[2] = mk(4'd6, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
    for (int i = 0; i < 3; i++) ex[i] = ref_encode(recs[i]);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_rec(recs[0]); @(posedge clk); #1;
    drive_rec(recs[1]); @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_full in_ready got %b want 0", bus.in_ready); else passes++;
    drive_rec(recs[2]);
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (bus.in_ready !== 1'b0 || {bus.out_err, bus.out_instr} !== ex[0])
        $display("FAIL b2b_hold in_ready %b word %h want 0 %h", bus.in_ready, bus.out_instr, ex[0][31:0]); else passes++;
    end
    bus.out_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
      bit push;
      push = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        checks++; if ({bus.out_err, bus.out_instr} !== ex[idx])
          $display("FAIL b2b_order%0d got %h want %h", idx, bus.out_instr, ex[idx][31:0]); else passes++;
        idx++;
      end
      @(posedge clk); #1;
      if (push) bus.in_valid = 1'b0;
    end
    checks++; if (idx != 3) $display("FAIL b2b_drain got %0d words want 3", idx); else passes++;
    checks++; if (bus.count !== 16'd3) $display("FAIL b2b_count got %0d want 3", bus.count); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_empty out_valid got %b want 0", bus.out_valid); else passes++;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit          ok;
    rec_t        r;
    logic [32:0] e;
    bus.out_ready = 1'b0;
    send_one(mk(4'd1, 5'd9, 5'd1, 5'd0, 3'd1, 7'd0, 32'd3), ok);
    send_one(mk(4'd0, 5'd8, 5'd2, 5'd3, 3'd4, 7'd32, 32'd0), ok);
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL rstmid_prefill valid %b ready %b want 1 0", bus.out_valid, bus.in_ready); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.count !== 16'd0) $display("FAIL rstmid_count got %0d want 0", bus.count); else passes++;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_instr !== 32'h0)
      $display("FAIL rstmid_state ready %b instr %h want 1 0", bus.in_ready, bus.out_instr); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_stale out_valid got %b want 0", bus.out_valid); else passes++;
    end
    r = mk(4'd8, 5'd1, 5'd5, 5'd0, 3'd7, 7'd0, 32'hFFFFF800);
    e = ref_encode(r);
    send_one(r, ok);
    checks++; if (!ok || bus.out_valid !== 1'b1 || {bus.out_err, bus.out_instr} !== e)
      $display("FAIL rstmid_resume got %b/%h want %h", bus.out_valid, bus.out_instr, e[31:0]); else passes++;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int xfers;
    int cyc;
    bit pop;
    apply_reset();
    drive_rec(mk(4'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    xfers = 0;
    cyc   = 0;
    while (xfers < 65535 && cyc < 70000) begin
      pop = bus.out_valid && bus.out_ready;
      @(posedge clk); #1;
      if (pop) xfers++;
      cyc++;
    end
    checks++; if (bus.count !== 16'hFFFF) $display("FAIL wrap_preset got %0d want 65535", bus.count); else passes++;
    pop = 1'b0;
    for (int i = 0; i < 5 && !pop; i++) begin
      pop = bus.out_valid && bus.out_ready;
      @(posedge clk); #1;
    end
    checks++; if (bus.count !== 16'd0) $display("FAIL wrap_count got %0d want 0", bus.count); else passes++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_rec(mk(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
